// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the EX-stage multiply/divide unit.
// The decoder, hazard unit and md_unit all use these op codes, so the
// encodings must stay stable.
//   md_op_e            : 3-bit MD operation code carried on md_unit.op
//   MD_MULT_CYCLES_DEF : default busy latency for MULT/MULTU
//   MD_DIV_CYCLES_DEF  : default busy latency for DIV/DIVU
//   md_max()           : larger of two ints, used to size the busy counter
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic int md_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result at the start edge into pending
// registers and commit them to HI/LO only when the latency counter runs out;
// MTHI/MTLO write HI/LO directly in one cycle.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, clears all state
//   start  : qualifies op this cycle
//   op     : md_op_e code (other codes are no-ops)
//   rs_val : forwarded GPR[rs]
//   rt_val : forwarded GPR[rt]
//   busy   : registered, high while a mult/div is in flight
//   hi, lo : architectural HI/LO
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;

  // Result arithmetic
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] divu_q;
  logic [31:0] divu_r;
  logic        div_zero;

  always_comb begin
    prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    div_zero = (rt_val == 32'd0);

    // Signed divide done on magnitudes so 0x8000_0000 / -1 wraps to
    // 0x8000_0000 deterministically instead of relying on simulator overflow.
    neg_a = rs_val[31];
    neg_b = rt_val[31];
    mag_a = neg_a ? (32'd0 - rs_val) : rs_val;
    mag_b = neg_b ? (32'd0 - rt_val) : rt_val;
    // Divisor forced nonzero; the divide-by-zero case is muxed in below.
    den   = div_zero ? 32'd1 : mag_b;
    uq    = mag_a / den;
    ur    = mag_a % den;
    div_q = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    div_r = neg_a ? (32'd0 - ur) : ur;

    divu_q = rs_val / (div_zero ? 32'd1 : rt_val);
    divu_r = rs_val % (div_zero ? 32'd1 : rt_val);

    if (div_zero) begin
      div_q  = 32'hFFFF_FFFF;
      div_r  = rs_val;
      divu_q = 32'hFFFF_FFFF;
      divu_r = rs_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (busy) begin
      // Any start seen here is dropped; the hazard unit never issues one.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
      end
    end else if (start) begin
      case (md_op_e'(op))
        MD_MULT: begin
          pend_hi <= prod_s[63:32];
          pend_lo <= prod_s[31:0];
          cnt     <= CW'(MULT_CYCLES);
          busy    <= 1'b1;
        end
        MD_MULTU: begin
          pend_hi <= prod_u[63:32];
          pend_lo <= prod_u[31:0];
          cnt     <= CW'(MULT_CYCLES);
          busy    <= 1'b1;
        end
        MD_DIV: begin
          pend_hi <= div_r;
          pend_lo <= div_q;
          cnt     <= CW'(DIV_CYCLES);
          busy    <= 1'b1;
        end
        MD_DIVU: begin
          pend_hi <= divu_r;
          pend_lo <= divu_q;
          cnt     <= CW'(DIV_CYCLES);
          busy    <= 1'b1;
        end
        MD_MTHI: hi <= rs_val;
        MD_MTLO: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage, alongside the ALU, feeding the EX→MEM pipeline register. It executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and MTHI/MTLO in a single cycle. It holds the architectural HI/LO registers and raises `busy` so the hazard unit stalls any following HI/LO-touching instruction in ID. MFHI/MFLO read `hi`/`lo` combinationally in EX and route the value into the ALU-output path to EX→MEM.

## Interface
- `MULT_CYCLES`, default 5, busy cycles for MULT/MULTU (≥1)
- `DIV_CYCLES`, default 10, busy cycles for DIV/DIVU (≥1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  qualifies `op` this cycle (EX instruction is an MD op, pipeline not flushed)
- `op`  in  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; other codes no-op
- `rs_val`  in  32  forwarded GPR[rs]
- `rt_val`  in  32  forwarded GPR[rt]
- `busy`  out  1  registered; high while a mult/div is in flight
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO

## Operation
- Reset: `busy`=0, `hi`=0, `lo`=0, counter=0, pending results=0. Reset mid-operation discards the pending result; no HI/LO write follows.
- Idle (`busy`=0), `start`=1, op MULT/MULTU/DIV/DIVU: at that edge compute the result into `pend_hi`/`pend_lo`, load counter with the latency, set `busy`=1.
- MULT: {HI,LO} = signed 64-bit rs×rt. MULTU: unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend. 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (both div ops): LO=0xFFFF_FFFF, HI=rs_val. Latency is unchanged.
- Busy: each edge decrements the counter. On the edge where it goes 1→0, copy the pending values to `hi`/`lo` and clear `busy`.
- MTHI/MTLO with `start`, idle: at that edge write `rs_val` to HI or LO. `busy` stays 0.
- `start` while `busy`=1: ignored entirely, with no state change. The hazard unit guarantees this never happens, and the bench asserts it.
- `hi`/`lo` keep their old values for the whole busy window. Only the final edge updates them.

## Timing
- Start sampled at edge E0. `busy` is high for exactly L cycles after E0, where L=MULT_CYCLES or DIV_CYCLES. At edge E0+L, `hi`/`lo` take the new values and `busy` falls in the same cycle.
- The hazard unit stalls ID when (`start` | `busy`) and the ID instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO.
- MTHI/MTLO: new value visible the cycle after E0 (latency 1).
- Back-to-back: a new `start` is legal in the first cycle that `busy`=0.

## Structure
- Shared package: the op codes (`MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`) and the default latency constants. The decoder and hazard unit use the same codes.
- Single module. The counter, pending registers, and HI/LO live in one sequential block. Result arithmetic is a combinational section inside it, so no sub-module is needed.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Test plan
- MULT rs=0xFFFF_FFFE (−2), rt=3 → `busy` high 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU with the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV rs=−7 (0xFFFF_FFF9), rt=2 → after 10 busy cycles LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0. DIVU 5/0 → LO=0xFFFF_FFFF, HI=5, `busy` still 10 cycles.
- MTHI 0x1234_5678 then MTLO 0x9ABC_DEF0 on consecutive cycles → HI and LO each updated one cycle after their start, `busy` never high.
- Start DIV, assert `reset` asynchronously at busy cycle 4 (mid-cycle) → `busy`, `hi`, `lo` go to 0 immediately, with no later write.
- Start MULT, pulse `start` with DIV during busy → ignored. The MULT result lands at E0+5. A new DIV started at the first non-busy cycle completes correctly.
